// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, WIDTH-cycle latency.
// Define MULT_SIGNED_EN to add the is_signed port and two's-complement operation.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
`ifdef MULT_SIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH:0]       acc_q;
  logic [WIDTH-1:0]     mq_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     a_load;
  logic [WIDTH-1:0]     mq_load;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod_raw;
  logic [2*WIDTH-1:0]   prod_final;

`ifdef MULT_SIGNED_EN
  logic sign_q;
  logic sign_load;
  logic neg_a;
  logic neg_b;

  always_comb begin
    neg_a     = is_signed & multiplicand[WIDTH-1];
    neg_b     = is_signed & multiplier[WIDTH-1];
    // Magnitude of the most negative value still fits WIDTH unsigned bits.
    a_load    = neg_a ? -multiplicand : multiplicand;
    mq_load   = neg_b ? -multiplier : multiplier;
    sign_load = neg_a ^ neg_b;
  end
`else
  always_comb begin
    a_load  = multiplicand;
    mq_load = multiplier;
  end
`endif

  always_comb begin
    // acc_q[WIDTH] is always zero here; the carry lives in sum[WIDTH].
    sum      = acc_q + (mq_q[0] ? {1'b0, a_q} : '0);
    prod_raw = {sum, mq_q[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
    prod_final = sign_q ? -prod_raw : prod_raw;
`else
    prod_final = prod_raw;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MULT_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q     <= a_load;
            acc_q   <= '0;
            mq_q    <= mq_load;
            cnt_q   <= CntW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= StRun;
`ifdef MULT_SIGNED_EN
            sign_q  <= sign_load;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q <= {1'b0, sum[WIDTH:1]};
          mq_q  <= {sum[0], mq_q[WIDTH-1:1]};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            product_q <= prod_final;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
